// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive controller.
package uart_rx_pkg;

  // Receive sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    LOAD  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter for the UART receiver. Counts 0..terminal and wraps,
// where terminal is either half or a full bit period.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_enable,
  input  logic                            i_half,
  output logic [$clog2(CLKS_PER_BIT)-1:0] o_count,
  output logic                            o_rollover
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);

  logic [TW-1:0] r_count;
  logic [TW-1:0] w_tc;

  assign w_tc       = i_half ? HALF_TC : FULL_TC;
  // Rollover does not look at i_clear so the FSM can derive clear from it.
  assign o_rollover = i_enable && (r_count == w_tc);
  assign o_count    = r_count;

  // Free-running period counter with synchronous clear and wrap at terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= TW'(0);
    end else if (i_clear) begin
      r_count <= TW'(0);
    end else if (i_enable) begin
      if (r_count == w_tc) begin
        r_count <= TW'(0);
      end else begin
        r_count <= r_count + TW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit qualification, mid-bit shift strobes,
// stop-bit check and receive-buffer status flags. No data path here; the
// shift register and buffer live outside and follow the strobes.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error
);

  import uart_rx_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  // The shift strobe is registered one cycle ahead so that it is high
  // during the terminal-count cycle, i.e. at the middle of each data bit.
  localparam logic [TW-1:0] SHIFT_LEAD = TW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_BITS - 1);

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic          r_prev_in;
  logic          w_edge;
  logic [TW-1:0] w_count;
  logic          w_rollover;
  logic          w_tmr_clear;
  logic          w_tmr_enable;
  logic          w_tmr_half;
  logic [CW-1:0] r_bit_count;
  logic          w_shift_set;
  logic          w_load_set;
  logic          w_framing_set;
  logic          w_framing_clr;
  logic          r_shift_enable;
  logic          r_load_buffer;
  logic          r_data_ready;
  logic          r_framing_error;
  logic          r_overrun_error;

  assign w_edge       = r_prev_in && !serial_in;
  assign w_tmr_enable = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_tmr_half   = (r_state == START);
  assign w_tmr_clear  = !w_tmr_enable || (w_state_next != r_state);

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_tmr_clear),
    .i_enable   (w_tmr_enable),
    .i_half     (w_tmr_half),
    .o_count    (w_count),
    .o_rollover (w_rollover)
  );

  // Delayed copy of the line for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_in <= 1'b1;
    end else begin
      r_prev_in <= serial_in;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and one-shot event decodes.
  always_comb begin
    w_state_next  = r_state;
    w_shift_set   = 1'b0;
    w_load_set    = 1'b0;
    w_framing_set = 1'b0;
    w_framing_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_rollover) begin
          if (serial_in) begin
            w_state_next = IDLE;
          end else begin
            w_state_next  = DATA;
            w_framing_clr = 1'b1;
          end
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        w_shift_set = (w_count == SHIFT_LEAD);
        if (w_rollover && (r_bit_count == LAST_BIT)) begin
          w_state_next = STOP;
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_rollover) begin
          if (serial_in) begin
            w_state_next = LOAD;
            w_load_set   = 1'b1;
          end else begin
            w_state_next  = IDLE;
            w_framing_set = 1'b1;
          end
        end else begin
          w_state_next = STOP;
        end
      end
      LOAD: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Data-bit counter, advanced at the end of each data bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_count <= CW'(0);
    end else if ((r_state == DATA) && w_rollover) begin
      if (r_bit_count == LAST_BIT) begin
        r_bit_count <= CW'(0);
      end else begin
        r_bit_count <= r_bit_count + CW'(1);
      end
    end else if (r_state != DATA) begin
      r_bit_count <= CW'(0);
    end
  end

  // Registered strobes to the external shift register and buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_enable <= 1'b0;
      r_load_buffer  <= 1'b0;
    end else begin
      r_shift_enable <= w_shift_set;
      r_load_buffer  <= w_load_set;
    end
  end

  // Status flags: a load wins over a coincident read and never flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      if (w_framing_set) begin
        r_framing_error <= 1'b1;
      end else if (w_framing_clr) begin
        r_framing_error <= 1'b0;
      end
      if (r_load_buffer) begin
        r_data_ready <= 1'b1;
        if (r_data_ready && !data_read) begin
          r_overrun_error <= 1'b1;
        end
      end else if (data_read && r_data_ready) begin
        r_data_ready    <= 1'b0;
        r_overrun_error <= 1'b0;
      end
    end
  end

  assign shift_enable  = r_shift_enable;
  assign load_buffer   = r_load_buffer;
  assign data_ready    = r_data_ready;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (CLKS_PER_BIT=10, DATA_BITS=8).
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b1;
  logic data_read = 1'b0;
  logic shift_enable, load_buffer, data_ready, framing_error, overrun_error;
  logic [4:0] outs;

  assign outs = {shift_enable, load_buffer, data_ready, framing_error, overrun_error};

  uart_rx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .shift_enable  (shift_enable),
    .load_buffer   (load_buffer),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  int e_cyc = 0;
  int total = 0;
  int bad = 0;
  int n_shift = 0, n_shift_bad = 0, n_load = 0;
  int load_off = -1, rdy_rise = -1, fe_rise = -1, fe_fall = -1;
  int base_s = 0, base_b = 0, base_l = 0;
  logic [7:0] sr_model = 8'h00;
  logic prev_rdy = 1'b0, prev_fe = 1'b0;

  // Shift strobes are legal only at the middle of data bits 0..7.
  function automatic bit shift_slot(input int off);
    return (off >= 15) && (off <= 85) && ((off - 15) % 10 == 0);
  endfunction

  // Cycle counter.
  always @(posedge clk) cnt <= cnt + 1;

  // Event recorder with a reference LSB-first shift register.
  always @(negedge clk) begin
    if (shift_enable) begin
      n_shift  <= n_shift + 1;
      sr_model <= {serial_in, sr_model[7:1]};
      if (!shift_slot(cnt - e_cyc)) n_shift_bad <= n_shift_bad + 1;
    end
    if (load_buffer) begin
      n_load   <= n_load + 1;
      load_off <= cnt - e_cyc;
    end
    if (data_ready && !prev_rdy) rdy_rise <= cnt - e_cyc;
    if (framing_error && !prev_fe) fe_rise <= cnt - e_cyc;
    if (!framing_error && prev_fe) fe_fall <= cnt - e_cyc;
    prev_rdy <= data_ready;
    prev_fe  <= framing_error;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    base_s = n_shift;
    base_b = n_shift_bad;
    base_l = n_load;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // One frame, cycle by cycle; optional read pulse or reset at an offset from E.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    e_cyc = cnt;
    for (int i = 0; i < 100; i++) begin
      serial_in = bits[i / 10];
      data_read = (i == rd_at);
      if (i == rst_at) begin
        rst = 1'b1;
        #2;
        check_eq("rst_async_outs", int'(outs), 0);
      end
      if ((rst_at >= 0) && (i == rst_at + 1)) begin
        rst = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    serial_in = 1'b1;
    data_read = 1'b0;
  endtask

  task automatic pulse_read();
    @(posedge clk); #1;
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input int n_ld);
    check_eq({tag, "_shifts"}, n_shift - base_s, 8);
    check_eq({tag, "_shift_pos"}, n_shift_bad - base_b, 0);
    check_eq({tag, "_loads"}, n_load - base_l, n_ld);
    if (n_ld > 0) begin
      check_eq({tag, "_load_off"}, load_off, 96);
      check_eq({tag, "_data"}, int'(sr_model), int'(d));
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", int'(outs), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Clean frame 0xA5.
    mark();
    send_frame(8'hA5, 1'b1, -1, -1);
    settle();
    check_frame("a5", 8'hA5, 1);
    check_eq("a5_ready_rise", rdy_rise, 97);
    check_eq("a5_fe_oe", int'({framing_error, overrun_error}), 0);
    pulse_read();
    check_eq("a5_read_clears", int'(data_ready), 0);

    // Three-cycle glitch, then a frame starting right when IDLE is regained.
    mark();
    @(posedge clk); #1;
    serial_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    serial_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    send_frame(8'h3C, 1'b1, -1, -1);
    settle();
    check_frame("glitch_3c", 8'h3C, 1);
    check_eq("glitch_fe_oe", int'({framing_error, overrun_error}), 0);

    // Bad stop bit while data_ready is still set.
    mark();
    send_frame(8'h5A, 1'b0, -1, -1);
    settle();
    check_frame("fe", 8'h5A, 0);
    check_eq("fe_rise", fe_rise, 96);
    check_eq("fe_ready_kept", int'(data_ready), 1);
    check_eq("fe_no_oe", int'(overrun_error), 0);

    // Next good frame clears framing error and overruns the unread byte.
    mark();
    send_frame(8'h81, 1'b1, -1, -1);
    settle();
    check_frame("ovr_81", 8'h81, 1);
    check_eq("fe_fall", fe_fall, 6);
    check_eq("ovr_flags", int'({data_ready, framing_error, overrun_error}), 5);
    pulse_read();
    check_eq("ovr_read_clears", int'({data_ready, overrun_error}), 0);

    // Read coincident with the second load.
    send_frame(8'h11, 1'b1, -1, -1);
    mark();
    send_frame(8'h22, 1'b1, 96, -1);
    settle();
    check_frame("coin_22", 8'h22, 1);
    check_eq("coin_flags", int'({data_ready, overrun_error}), 2);

    // Reset mid-frame, then idle, then a full frame.
    send_frame(8'hE7, 1'b1, -1, 40);
    mark();
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_eq("rst_idle_outs", int'(outs), 0);
    check_eq("rst_idle_shifts", n_shift - base_s, 0);
    mark();
    send_frame(8'hC3, 1'b1, -1, -1);
    settle();
    check_frame("post_rst_c3", 8'hC3, 1);
    check_eq("post_rst_flags", int'({data_ready, framing_error, overrun_error}), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
